// File: rtl/seq_code_lock_pkg.sv
// Shared types and constants for the sequential code lock.
package seq_code_lock_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ENTRY,
    LOCKOUT
  } state_t;

  localparam int MAX_DIGIT = 9;

  // Digits 1,2,3,4 with the first digit in the LSBs
  localparam logic [15:0] DEFAULT_CODE = 16'h4321;

endpackage

// File: rtl/seq_code_lock_if.sv
// Keypad, code-load and status bundle for the code lock.
interface seq_code_lock_if #(
  parameter int CODE_LEN  = 4,
  parameter int DIGIT_W   = 4,
  parameter int MAX_FAILS = 3
);

  localparam int FC_W = $clog2(MAX_FAILS + 1);
  localparam int EC_W = $clog2(CODE_LEN + 1);

  logic                        key_valid;
  logic [DIGIT_W-1:0]          key_digit;
  logic                        code_load;
  logic [CODE_LEN*DIGIT_W-1:0] code_word;
  logic                        correct_signal;
  logic                        alarm;
  logic                        locked_out;
  logic [FC_W-1:0]             fail_count;
  logic [EC_W-1:0]             entry_count;

  modport master (
    output key_valid, key_digit, code_load, code_word,
    input  correct_signal, alarm, locked_out,
    input  fail_count, entry_count
  );

  modport slave (
    input  key_valid, key_digit, code_load, code_word,
    output correct_signal, alarm, locked_out,
    output fail_count, entry_count
  );

endinterface

// File: rtl/seq_code_lock_timer.sv
// Loadable down-counter; done while the count sits at zero.
module lock_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (cnt != '0)
      cnt <= cnt - 1'b1;
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/seq_code_lock.sv
// Sequential keypad lock with fail counting, alarm,
// timed lockout and partial-entry timeout.
module seq_code_lock #(
  parameter int CODE_LEN       = 4,
  parameter int DIGIT_W        = 4,
  parameter int MAX_FAILS      = 3,
  parameter int LOCKOUT_CYCLES = 16,
  parameter int ENTRY_TIMEOUT  = 32
) (
  input logic          clk,
  input logic          reset,
  seq_code_lock_if.slave bus
);

  import seq_code_lock_pkg::*;

  localparam int CW   = CODE_LEN * DIGIT_W;
  localparam int FC_W = $clog2(MAX_FAILS + 1);
  localparam int EC_W = $clog2(CODE_LEN + 1);
  localparam int LK_W = $clog2(LOCKOUT_CYCLES + 1);
  localparam int TO_W = $clog2(ENTRY_TIMEOUT + 1);

  state_t             state;
  logic [CW-1:0]      code;
  logic [EC_W-1:0]    entry_count;
  logic [FC_W-1:0]    fail_count;
  logic               mismatch;
  logic               correct_r;
  logic               alarm_r;
  logic               locked_r;

  logic               accept;
  logic               last;
  logic               att_bad;
  logic               trip;
  logic               lk_done;
  logic               to_done;
  logic [DIGIT_W-1:0] exp_digit;

  always_comb begin
    exp_digit = '0;
    for (int i = 0; i < CODE_LEN; i++)
      if (entry_count == EC_W'(i))
        exp_digit = code[i*DIGIT_W +: DIGIT_W];
  end

  assign accept  = bus.key_valid && (state != LOCKOUT);
  assign last    = (entry_count == EC_W'(CODE_LEN - 1));
  // Mismatch history only counts once past the first digit
  assign att_bad = ((entry_count != '0) && mismatch)
                || (bus.key_digit > DIGIT_W'(MAX_DIGIT))
                || (bus.key_digit != exp_digit);
  assign trip    = accept && last && att_bad
                && (fail_count == FC_W'(MAX_FAILS - 1));

  lock_timer #(.W(LK_W)) u_lk (
    .clk      (clk),
    .reset    (reset),
    .load     (trip),
    .load_val (LK_W'(LOCKOUT_CYCLES - 1)),
    .done     (lk_done)
  );

  lock_timer #(.W(TO_W)) u_to (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .load_val (TO_W'(ENTRY_TIMEOUT - 1)),
    .done     (to_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      code        <= CW'(DEFAULT_CODE);
      entry_count <= '0;
      fail_count  <= '0;
      mismatch    <= 1'b0;
      correct_r   <= 1'b0;
      alarm_r     <= 1'b0;
      locked_r    <= 1'b0;
    end else begin
      correct_r <= 1'b0;
      unique case (state)
        IDLE, ENTRY: begin
          if (accept && !last) begin
            state       <= ENTRY;
            entry_count <= entry_count + 1'b1;
            mismatch    <= att_bad;
          end else if (accept) begin
            state       <= IDLE;
            entry_count <= '0;
            mismatch    <= 1'b0;
            if (!att_bad) begin
              correct_r  <= 1'b1;
              fail_count <= '0;
              alarm_r    <= 1'b0;
            end else if (trip) begin
              state      <= LOCKOUT;
              fail_count <= FC_W'(MAX_FAILS);
              alarm_r    <= 1'b1;
              locked_r   <= 1'b1;
            end else begin
              fail_count <= fail_count + 1'b1;
            end
          end else if (state == ENTRY && to_done) begin
            state       <= IDLE;
            entry_count <= '0;
            mismatch    <= 1'b0;
          end else if (state == IDLE && bus.code_load) begin
            code <= bus.code_word;
          end
        end
        LOCKOUT: begin
          if (lk_done) begin
            state      <= IDLE;
            locked_r   <= 1'b0;
            fail_count <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.correct_signal = correct_r;
  assign bus.alarm          = alarm_r;
  assign bus.locked_out     = locked_r;
  assign bus.fail_count     = fail_count;
  assign bus.entry_count    = entry_count;

endmodule

// File: tb/tb_seq_code_lock.sv
// Directed self-checking bench for seq_code_lock.
module tb_seq_code_lock;

  logic clk;
  logic reset;
  int   passed;
  int   total;

  seq_code_lock_if #(.CODE_LEN(4), .DIGIT_W(4), .MAX_FAILS(3)) bus ();

  seq_code_lock dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic press(input logic [3:0] d);
    @(negedge clk);
    bus.key_valid = 1'b1;
    bus.key_digit = d;
    @(negedge clk);
    bus.key_valid = 1'b0;
  endtask

  task automatic enter(input logic [15:0] w);
    for (int i = 0; i < 4; i++) press(w[i*4 +: 4]);
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    total++; if ({bus.correct_signal, bus.alarm, bus.locked_out} !== 3'b000) $display("FAIL rst_flags got %b want 000", {bus.correct_signal, bus.alarm, bus.locked_out}); else passed++;
    total++; if (bus.fail_count !== 2'd0) $display("FAIL rst_fail got %0d want 0", bus.fail_count); else passed++;
    total++; if (bus.entry_count !== 3'd0) $display("FAIL rst_entry got %0d want 0", bus.entry_count); else passed++;
    reset = 1'b0;
  endtask

  task automatic test_correct;
    press(4'd1); press(4'd2); press(4'd3);
    total++; if (bus.entry_count !== 3'd3) $display("FAIL cor_entry3 got %0d want 3", bus.entry_count); else passed++;
    press(4'd4);
    total++; if (bus.correct_signal !== 1'b1) $display("FAIL cor_pulse got %b want 1", bus.correct_signal); else passed++;
    total++; if (bus.entry_count !== 3'd0) $display("FAIL cor_entry0 got %0d want 0", bus.entry_count); else passed++;
    total++; if ({bus.alarm, bus.fail_count} !== 3'b000) $display("FAIL cor_alarm_fail got %b want 000", {bus.alarm, bus.fail_count}); else passed++;
    @(negedge clk);
    total++; if (bus.correct_signal !== 1'b0) $display("FAIL cor_pulse_end got %b want 0", bus.correct_signal); else passed++;
  endtask

  task automatic test_lockout;
    for (int a = 1; a <= 3; a++) begin
      enter(16'h5321);
      total++; if (bus.fail_count !== 2'(a)) $display("FAIL lk_fail%0d got %0d want %0d", a, bus.fail_count, a); else passed++;
      total++; if (bus.correct_signal !== 1'b0) $display("FAIL lk_nopulse%0d got %b want 0", a, bus.correct_signal); else passed++;
    end
    total++; if ({bus.alarm, bus.locked_out} !== 2'b11) $display("FAIL lk_enter got %b want 11", {bus.alarm, bus.locked_out}); else passed++;
    bus.key_valid = 1'b1;
    bus.key_digit = 4'd1;
    bus.code_load = 1'b1;
    bus.code_word = 16'h6789;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      total++; if ({bus.locked_out, bus.entry_count} !== 4'b1000) $display("FAIL lk_hold%0d got %b want 1000", k, {bus.locked_out, bus.entry_count}); else passed++;
    end
    @(negedge clk);
    bus.key_valid = 1'b0;
    bus.code_load = 1'b0;
    total++; if (bus.locked_out !== 1'b0) $display("FAIL lk_exit got %b want 0", bus.locked_out); else passed++;
    total++; if (bus.fail_count !== 2'd0) $display("FAIL lk_failclr got %0d want 0", bus.fail_count); else passed++;
    total++; if (bus.alarm !== 1'b1) $display("FAIL lk_alarm_sticky got %b want 1", bus.alarm); else passed++;
    enter(16'h4321);
    total++; if (bus.correct_signal !== 1'b1) $display("FAIL lk_unlock got %b want 1", bus.correct_signal); else passed++;
    total++; if (bus.alarm !== 1'b0) $display("FAIL lk_alarm_clr got %b want 0", bus.alarm); else passed++;
  endtask

  task automatic test_timeout;
    press(4'd1); press(4'd2);
    repeat (31) @(negedge clk);
    total++; if (bus.entry_count !== 3'd2) $display("FAIL to_before got %0d want 2", bus.entry_count); else passed++;
    @(negedge clk);
    total++; if (bus.entry_count !== 3'd0) $display("FAIL to_abort got %0d want 0", bus.entry_count); else passed++;
    total++; if (bus.fail_count !== 2'd0) $display("FAIL to_nofail got %0d want 0", bus.fail_count); else passed++;
    enter(16'h4321);
    total++; if (bus.correct_signal !== 1'b1) $display("FAIL to_after got %b want 1", bus.correct_signal); else passed++;
  endtask

  task automatic test_code_load;
    @(negedge clk);
    bus.code_load = 1'b1;
    bus.code_word = 16'h6789;
    @(negedge clk);
    bus.code_load = 1'b0;
    enter(16'h4321);
    total++; if ({bus.correct_signal, bus.fail_count} !== 3'b001) $display("FAIL cl_old got %b want 001", {bus.correct_signal, bus.fail_count}); else passed++;
    enter(16'h6789);
    total++; if ({bus.correct_signal, bus.fail_count} !== 3'b100) $display("FAIL cl_new got %b want 100", {bus.correct_signal, bus.fail_count}); else passed++;
    press(4'd9);
    @(negedge clk);
    bus.code_load = 1'b1;
    bus.code_word = 16'h4321;
    @(negedge clk);
    bus.code_load = 1'b0;
    press(4'd8); press(4'd7); press(4'd6);
    total++; if (bus.correct_signal !== 1'b1) $display("FAIL cl_entry_ign got %b want 1", bus.correct_signal); else passed++;
    @(negedge clk);
    bus.key_valid = 1'b1;
    bus.key_digit = 4'd9;
    bus.code_load = 1'b1;
    bus.code_word = 16'h4321;
    @(negedge clk);
    bus.key_valid = 1'b0;
    bus.code_load = 1'b0;
    total++; if (bus.entry_count !== 3'd1) $display("FAIL cl_both_key got %0d want 1", bus.entry_count); else passed++;
    press(4'd8); press(4'd7); press(4'd6);
    total++; if (bus.correct_signal !== 1'b1) $display("FAIL cl_both_drop got %b want 1", bus.correct_signal); else passed++;
  endtask

  task automatic test_bad_digit;
    enter(16'h67C9);
    total++; if ({bus.correct_signal, bus.fail_count} !== 3'b001) $display("FAIL bd_fail got %b want 001", {bus.correct_signal, bus.fail_count}); else passed++;
    enter(16'h6789);
    total++; if ({bus.correct_signal, bus.fail_count} !== 3'b100) $display("FAIL bd_recover got %b want 100", {bus.correct_signal, bus.fail_count}); else passed++;
  endtask

  task automatic test_reset_mid;
    enter(16'h4321);
    total++; if (bus.fail_count !== 2'd1) $display("FAIL rm_pre got %0d want 1", bus.fail_count); else passed++;
    press(4'd1); press(4'd2);
    #2 reset = 1'b1;
    #1;
    total++; if ({bus.correct_signal, bus.alarm, bus.locked_out, bus.fail_count, bus.entry_count} !== 8'd0) $display("FAIL rm_async got %b want 0", {bus.correct_signal, bus.alarm, bus.locked_out, bus.fail_count, bus.entry_count}); else passed++;
    @(negedge clk);
    reset = 1'b0;
    enter(16'h4321);
    total++; if (bus.correct_signal !== 1'b1) $display("FAIL rm_default got %b want 1", bus.correct_signal); else passed++;
  endtask

  initial begin
    passed = 0;
    total = 0;
    reset = 1'b1;
    bus.key_valid = 1'b0;
    bus.key_digit = '0;
    bus.code_load = 1'b0;
    bus.code_word = '0;
    test_reset;
    test_correct;
    test_lockout;
    test_timeout;
    test_code_load;
    test_bad_digit;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
